// File: rtl/csa_select_pipe_if.sv
// Handshake and data bundle between the dual-sum block, the carry-select pipeline and its consumer.
// The master modport is the producer/consumer side; the slave modport is the pipeline side.
interface csa_select_pipe_if #(
   parameter int WIDTH = 8,
   parameter int NBLK  = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    c_in;
   logic [NBLK*WIDTH-1:0]   s1_bus;
   logic [NBLK*WIDTH-1:0]   s2_bus;
   logic [NBLK-1:0]         c_out1;
   logic [NBLK-1:0]         c_out2;
   logic                    out_valid;
   logic                    out_ready;
   logic [NBLK*WIDTH-1:0]   sum;
   logic                    c_out;

   modport master (
      output in_valid, c_in, s1_bus, s2_bus, c_out1, c_out2, out_ready,
      input  in_ready, out_valid, sum, c_out
   );

   modport slave (
      input  in_valid, c_in, s1_bus, s2_bus, c_out1, c_out2, out_ready,
      output in_ready, out_valid, sum, c_out
   );
endinterface

// File: rtl/csa_select_pipe.sv
// Carry-select resolution pipeline: one adder block's real carry is resolved per stage,
// picking between the precomputed carry-in-0 and carry-in-1 candidates.
module csa_select_pipe #(
   parameter int WIDTH = 8,
   parameter int NBLK  = 4
) (
   input logic               clk,
   input logic               rst_n,
   csa_select_pipe_if.slave  bus
);
   localparam int TW = NBLK * WIDTH;

   logic            advance;
   logic [NBLK-1:0] vld_p;
   logic [TW-1:0]   sum_q;
   logic            c_out_q;
   logic [WIDTH:0]  res0;
   logic [TW-1:0]   fin_sum;
   logic            fin_c;

   // Returns {carry_out, block_sum} for the candidate chosen by the real carry-in.
   function automatic logic [WIDTH:0] resolve(
      input logic             ck,
      input logic [WIDTH-1:0] s1,
      input logic [WIDTH-1:0] s2,
      input logic             c1,
      input logic             c2
   );
      return ck ? {c2, s2} : {c1, s1};
   endfunction

   function automatic logic [TW-1:0] place_block(
      input logic [TW-1:0]    prev,
      input logic [WIDTH-1:0] blk,
      input int               idx
   );
      logic [TW-1:0] r;
      r = prev;
      r[idx*WIDTH +: WIDTH] = blk;
      return r;
   endfunction

   assign advance        = !vld_p[NBLK-1] || bus.out_ready;
   assign bus.in_ready   = advance;
   assign bus.out_valid  = vld_p[NBLK-1];
   assign bus.sum        = sum_q;
   assign bus.c_out      = c_out_q;

   assign res0 = resolve(bus.c_in, bus.s1_bus[WIDTH-1:0], bus.s2_bus[WIDTH-1:0],
                         bus.c_out1[0], bus.c_out2[0]);

   generate
      if (NBLK == 1) begin : g_single
         assign fin_sum = res0[WIDTH-1:0];
         assign fin_c   = res0[WIDTH];
      end else begin : g_multi
         localparam int MS = NBLK - 1;

         // Intermediate stages 0..NBLK-2; the last stage is the output register below.
         logic [TW-1:0]   sum_p   [MS];
         logic            carry_p [MS];
         logic [TW-1:0]   s1_p    [MS];
         logic [TW-1:0]   s2_p    [MS];
         logic [NBLK-1:0] co1_p   [MS];
         logic [NBLK-1:0] co2_p   [MS];
         logic [WIDTH:0]  res     [NBLK];
         logic [TW-1:0]   nsum    [NBLK];

         assign res[0]  = res0;
         assign nsum[0] = TW'(res0[WIDTH-1:0]);

         for (genvar j = 1; j < NBLK; j++) begin : g_blk
            assign res[j]  = resolve(carry_p[j-1],
                                     s1_p[j-1][j*WIDTH +: WIDTH],
                                     s2_p[j-1][j*WIDTH +: WIDTH],
                                     co1_p[j-1][j], co2_p[j-1][j]);
            assign nsum[j] = place_block(sum_p[j-1], res[j][WIDTH-1:0], j);
         end

         always_ff @(posedge clk) begin
            if (advance) begin
               for (int j = 0; j < MS; j++) begin
                  sum_p[j]   <= nsum[j];
                  carry_p[j] <= res[j][WIDTH];
               end
               s1_p[0]  <= bus.s1_bus;
               s2_p[0]  <= bus.s2_bus;
               co1_p[0] <= bus.c_out1;
               co2_p[0] <= bus.c_out2;
               for (int j = 1; j < MS; j++) begin
                  s1_p[j]  <= s1_p[j-1];
                  s2_p[j]  <= s2_p[j-1];
                  co1_p[j] <= co1_p[j-1];
                  co2_p[j] <= co2_p[j-1];
               end
            end
         end

         assign fin_sum = nsum[NBLK-1];
         assign fin_c   = res[NBLK-1][WIDTH];
      end
   endgenerate

   // Output stage: valid chain plus the visible result, both cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else if (advance) begin
         vld_p   <= NBLK'({vld_p, bus.in_valid});
         sum_q   <= fin_sum;
         c_out_q <= fin_c;
      end
   end
endmodule

// File: tb/tb_csa_select_pipe.sv
// Bench for csa_select_pipe: directed latency/stall/reset steps plus randomized traffic
// checked against plain-addition expectations for a 4-block and a 1-block instance.
module tb_csa_select_pipe;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   takes4;

   logic [32:0] cur4;
   logic [8:0]  cur1;
   logic [32:0] q4[$];
   logic [8:0]  q1[$];
   logic [32:0] exp3 [4];

   csa_select_pipe_if #(.WIDTH(8), .NBLK(4)) b4 ();
   csa_select_pipe_if #(.WIDTH(8), .NBLK(1)) b1 ();

   csa_select_pipe #(.WIDTH(8), .NBLK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   csa_select_pipe #(.WIDTH(8), .NBLK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Candidates come from adding the operand blocks; expectation is the plain full-width sum.
   task automatic drive4(input logic [31:0] a, input logic [31:0] b, input logic ci);
      logic [8:0] t0;
      logic [8:0] t1;
      for (int k = 0; k < 4; k++) begin
         t0 = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]};
         t1 = t0 + 9'd1;
         b4.s1_bus[k*8 +: 8] = t0[7:0];
         b4.c_out1[k]        = t0[8];
         b4.s2_bus[k*8 +: 8] = t1[7:0];
         b4.c_out2[k]        = t1[8];
      end
      b4.c_in = ci;
      cur4 = {1'b0, a} + {1'b0, b} + 33'(ci);
   endtask

   task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [8:0] t0;
      t0 = {1'b0, a} + {1'b0, b};
      b1.s1_bus    = t0[7:0];
      b1.c_out1[0] = t0[8];
      t0 = t0 + 9'd1;
      b1.s2_bus    = t0[7:0];
      b1.c_out2[0] = t0[8];
      b1.c_in      = ci;
      cur1 = {1'b0, a} + {1'b0, b} + 9'(ci);
   endtask

   // One clock of scoreboarded traffic on both instances.
   task automatic step();
      logic [32:0] e4;
      logic [8:0]  e1;
      #1;
      if (b4.out_valid && b4.out_ready) begin
         takes4++;
         if (q4.size() == 0) check("d4_extra_output", b4.out_valid, 1'b0);
         else begin
            e4 = q4.pop_front();
            check("d4_result", {b4.c_out, b4.sum}, e4);
         end
      end
      if (b4.in_valid && b4.in_ready) q4.push_back(cur4);
      if (b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) check("d1_extra_output", b1.out_valid, 1'b0);
         else begin
            e1 = q1.pop_front();
            check("d1_result", {b1.c_out, b1.sum}, e1);
         end
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(cur1);
      tick();
   endtask

   initial begin
      checks = 0; errors = 0; takes4 = 0;
      rst_n = 1'b0;
      b4.in_valid = 1'b0; b4.out_ready = 1'b0;
      b1.in_valid = 1'b0; b1.out_ready = 1'b0;
      drive4(32'h0, 32'h0, 1'b0);
      drive1(8'h0, 8'h0, 1'b0);
      repeat (2) tick();
      check("rst_out_valid", b4.out_valid, 1'b0);
      check("rst_sum", b4.sum, 32'h0);
      check("rst_c_out", b4.c_out, 1'b0);
      check("rst_in_ready", b4.in_ready, 1'b1);
      check("rst_d1_out_valid", b1.out_valid, 1'b0);
      check("rst_d1_sum", b1.sum, 8'h0);
      rst_n = 1'b1;
      tick();

      // Carry ripples out of block 0 only: 0xFF + 0x01.
      drive4(32'h000000FF, 32'h00000001, 1'b0);
      b4.in_valid = 1'b1; b4.out_ready = 1'b1;
      #1;
      check("t1_in_ready", b4.in_ready, 1'b1);
      tick();
      b4.in_valid = 1'b0;
      for (int e = 0; e < 3; e++) begin
         check("t1_latency_vld", b4.out_valid, 1'b0);
         tick();
      end
      check("t1_out_valid", b4.out_valid, 1'b1);
      check("t1_sum", b4.sum, 32'h00000100);
      check("t1_c_out", b4.c_out, 1'b0);
      tick();
      check("t1_bubble_after", b4.out_valid, 1'b0);

      // Carry ripples through every block: 0xFFFFFFFF + 0 + 1.
      drive4(32'hFFFFFFFF, 32'h0, 1'b1);
      b4.in_valid = 1'b1;
      tick();
      b4.in_valid = 1'b0;
      repeat (3) tick();
      check("t2_out_valid", b4.out_valid, 1'b1);
      check("t2_sum", b4.sum, 32'h00000000);
      check("t2_c_out", b4.c_out, 1'b1);
      tick();

      // Back-to-back bundles with the consumer always ready.
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            drive4($urandom, $urandom, 1'($urandom_range(0, 1)));
            exp3[i] = cur4;
            b4.in_valid = 1'b1;
         end else b4.in_valid = 1'b0;
         #1;
         check("t3_in_ready", b4.in_ready, 1'b1);
         tick();
         if (i >= 3 && i < 7) begin
            check("t3_out_valid", b4.out_valid, 1'b1);
            check("t3_result", {b4.c_out, b4.sum}, exp3[i-3]);
         end else if (i == 7) check("t3_drained", b4.out_valid, 1'b0);
      end

      // Fill with the consumer stalled, hold for three cycles, then drain in order.
      b4.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive4($urandom, $urandom, 1'($urandom_range(0, 1)));
         b4.in_valid = 1'b1;
         step();
      end
      check("t4_full_vld", b4.out_valid, 1'b1);
      takes4 = 0;
      drive4(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_stall_in_ready", b4.in_ready, 1'b0);
         check("t4_stall_vld", b4.out_valid, 1'b1);
         check("t4_stall_hold", {b4.c_out, b4.sum}, q4[0]);
         step();
      end
      b4.out_ready = 1'b1;
      step();
      b4.in_valid = 1'b0;
      for (int i = 0; i < 12 && q4.size() > 0; i++) step();
      step();
      check("t4_queue_empty", 64'(q4.size()), 64'd0);
      check("t4_outputs_seen", 64'(takes4), 64'd5);

      // Asynchronous reset with a full pipeline.
      b4.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive4(32'h12345678 + 32'(i), 32'h11111111, 1'b0);
         b4.in_valid = 1'b1;
         step();
      end
      b4.in_valid = 1'b0;
      check("t5_pre_vld", b4.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_vld", b4.out_valid, 1'b0);
      check("t5_rst_sum", b4.sum, 32'h0);
      check("t5_rst_c_out", b4.c_out, 1'b0);
      q4.delete();
      tick();
      rst_n = 1'b1;
      drive4(32'h0F0F0F0F, 32'h01010101, 1'b1);
      b4.in_valid = 1'b1; b4.out_ready = 1'b1;
      tick();
      b4.in_valid = 1'b0;
      for (int e = 0; e < 3; e++) begin
         check("t5_alone_vld", b4.out_valid, 1'b0);
         tick();
      end
      check("t5_out_valid", b4.out_valid, 1'b1);
      check("t5_result", {b4.c_out, b4.sum}, 33'h010101011);
      tick();
      check("t5_single", b4.out_valid, 1'b0);

      // Single-block instance: latency one, selection driven by c_in.
      b1.c_in = 1'b1;
      b1.s1_bus = 8'h12; b1.c_out1[0] = 1'b0;
      b1.s2_bus = 8'h13; b1.c_out2[0] = 1'b1;
      b1.in_valid = 1'b1; b1.out_ready = 1'b0;
      #1;
      check("t6_in_ready", b1.in_ready, 1'b1);
      tick();
      b1.in_valid = 1'b0;
      check("t6_out_valid", b1.out_valid, 1'b1);
      check("t6_sum", b1.sum, 8'h13);
      check("t6_c_out", b1.c_out, 1'b1);
      check("t6_stall_in_ready", b1.in_ready, 1'b0);
      tick();
      check("t6_stall_hold", {b1.c_out, b1.sum}, 9'h113);
      b1.out_ready = 1'b1;
      tick();
      check("t6_drained", b1.out_valid, 1'b0);

      // Randomized traffic with random back-pressure on both instances.
      for (int i = 0; i < 300; i++) begin
         drive4($urandom, $urandom, 1'($urandom_range(0, 1)));
         drive1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         b4.in_valid  = ($urandom_range(0, 3) != 0);
         b4.out_ready = ($urandom_range(0, 3) != 0);
         b1.in_valid  = ($urandom_range(0, 3) != 0);
         b1.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      b4.in_valid = 1'b0; b1.in_valid = 1'b0;
      b4.out_ready = 1'b1; b1.out_ready = 1'b1;
      for (int i = 0; i < 12 && (q4.size() > 0 || q1.size() > 0); i++) step();
      check("rand_d4_drained", 64'(q4.size()), 64'd0);
      check("rand_d1_drained", 64'(q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
